// File: rtl/apb_initiator_bridge.sv
// Bridges a valid/ready request/response interface to single, non-pipelined APB4 transfers.
// Optional ACCESS wait-state timeout is enabled by defining APB_TIMEOUT_EN.
module apb_initiator_bridge #(
    parameter int          ADDR_W         = 32,
    parameter logic [2:0]  PPROT_VAL      = 3'b000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              out_psel,
    output logic              out_penable,
    output logic [2:0]        out_pprot,
    output logic [ADDR_W-1:0] out_paddr,
    output logic              out_pwrite,
    output logic [31:0]       out_pwdata,
    output logic [3:0]        out_pstrb,
    input  logic              in_pready,
    input  logic [31:0]       in_prdata,
    input  logic              in_pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] paddr_d;
    logic              pwrite_d, psel_d, penable_d, resp_valid_d, resp_err_d;
    logic [31:0]       pwdata_d, resp_rdata_d;
    logic [3:0]        pstrb_d;
    logic              timeout;

`ifdef APB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] wait_cnt;

    assign timeout = (state == ACCESS) && (wait_cnt == TIMEOUT_LIMIT);

    // Cleared while in SETUP so every ACCESS phase starts counting from zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !in_pready && !timeout) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign req_ready = (state == IDLE);
    assign out_pprot = PPROT_VAL;

    // NOTE: every signal gets a hold-value default before the case so no latch is inferred.
    always_comb begin
        state_d      = state;
        paddr_d      = out_paddr;
        pwrite_d     = out_pwrite;
        pwdata_d     = out_pwdata;
        pstrb_d      = out_pstrb;
        psel_d       = out_psel;
        penable_d    = out_penable;
        resp_valid_d = resp_valid;
        resp_rdata_d = resp_rdata;
        resp_err_d   = resp_err;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    paddr_d   = req_addr;
                    pwrite_d  = req_write;
                    pwdata_d  = req_write ? req_wdata : 32'h0;
                    pstrb_d   = req_write ? req_wstrb : 4'h0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // Timeout has priority over a pready arriving in the same cycle.
                if (timeout) begin
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = 32'hDEAD_0000;
                    resp_err_d   = 1'b1;
                    state_d      = RESP;
                end else if (in_pready) begin
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = out_pwrite ? 32'h0 : in_prdata;
                    resp_err_d   = in_pslverr;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            out_paddr   <= '0;
            out_pwrite  <= 1'b0;
            out_pwdata  <= '0;
            out_pstrb   <= '0;
            out_psel    <= 1'b0;
            out_penable <= 1'b0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
        end else begin
            state       <= state_d;
            out_paddr   <= paddr_d;
            out_pwrite  <= pwrite_d;
            out_pwdata  <= pwdata_d;
            out_pstrb   <= pstrb_d;
            out_psel    <= psel_d;
            out_penable <= penable_d;
            resp_valid  <= resp_valid_d;
            resp_rdata  <= resp_rdata_d;
            resp_err    <= resp_err_d;
        end
    end

endmodule
